// File: rtl/chk_pkg.sv
// Shared definitions for the output self-check monitor: FSM encoding, lane sizing
// and the mismatch popcount.
package chk_pkg;

  typedef enum logic [1:0] {
    CHK_RUN   = 2'd0,
    CHK_DRAIN = 2'd1,
    CHK_DONE  = 2'd2
  } chk_state_e;

  localparam int unsigned LaneW    = 8;
  localparam int unsigned MaxLanes = 8;

  function automatic logic [3:0] popcount(input logic [MaxLanes-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MaxLanes; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/lane_cmp.sv
// Parallel per-lane equality comparators; a mask bit is set where a lane differs
// from its expected value.
module lane_cmp
  import chk_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned W     = LaneW
) (
  input  logic [LANES*W-1:0] lane_i,
  input  logic [LANES*W-1:0] exp_i,
  output logic [LANES-1:0]   mask_o
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign mask_o[i] = (lane_i[i*W +: W] != exp_i[i*W +: W]);
  end

endmodule

// File: rtl/out_check_monitor.sv
// Single-shot result checker: compares all lanes at one programmed cycle after reset,
// waits a drain period, then latches a sticky pass/fail verdict.
module out_check_monitor
  import chk_pkg::*;
#(
  parameter int unsigned LANES        = 4,
  parameter int unsigned W            = LaneW,
  parameter int unsigned CHECK_CYCLE  = 3,
  parameter int unsigned DRAIN_CYCLES = 99,
  parameter int unsigned CW           = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LANES*W-1:0] lane_in,
  input  logic [LANES*W-1:0] exp_in,
  output logic [LANES-1:0]   mis_mask,
  output logic [3:0]         err_cnt,
  output logic               checked,
  output logic               pass,
  output logic               fail,
  output logic               done
);

  localparam logic [CW-1:0] CheckAt   = CW'(CHECK_CYCLE);
  // Guarded so a zero drain length does not wrap; DRAIN is unreachable then anyway.
  localparam logic [CW-1:0] DrainLast = (DRAIN_CYCLES == 0) ? '0 : CW'(DRAIN_CYCLES - 1);

  chk_state_e         state_q, state_d;
  logic [CW-1:0]      cyc_q, cyc_d;
  logic [LANES-1:0]   mis_mask_q, mis_mask_d;
  logic [3:0]         err_cnt_q, err_cnt_d;
  logic               checked_q, checked_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               done_q, done_d;

  logic [LANES-1:0]    cmp_mask;
  logic [MaxLanes-1:0] cmp_mask_ext;

  lane_cmp #(
    .LANES (LANES),
    .W     (W)
  ) u_lane_cmp (
    .lane_i (lane_in),
    .exp_i  (exp_in),
    .mask_o (cmp_mask)
  );

  assign cmp_mask_ext = MaxLanes'(cmp_mask);

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    mis_mask_d = mis_mask_q;
    err_cnt_d  = err_cnt_q;
    checked_d  = checked_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    done_d     = done_q;
    case (state_q)
      CHK_RUN: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == CheckAt) begin
          mis_mask_d = cmp_mask;
          err_cnt_d  = popcount(cmp_mask_ext);
          checked_d  = 1'b1;
          cyc_d      = '0;
          if (DRAIN_CYCLES == 0) begin
            state_d = CHK_DONE;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == 4'd0);
            fail_d  = (err_cnt_d != 4'd0);
          end else begin
            state_d = CHK_DRAIN;
          end
        end
      end
      CHK_DRAIN: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == DrainLast) begin
          state_d = CHK_DONE;
          done_d  = 1'b1;
          pass_d  = (err_cnt_q == 4'd0);
          fail_d  = (err_cnt_q != 4'd0);
        end
      end
      CHK_DONE: begin
        state_d = CHK_DONE;
      end
      default: begin
        state_d = CHK_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CHK_RUN;
      cyc_q      <= '0;
      mis_mask_q <= '0;
      err_cnt_q  <= '0;
      checked_q  <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      mis_mask_q <= mis_mask_d;
      err_cnt_q  <= err_cnt_d;
      checked_q  <= checked_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      done_q     <= done_d;
    end
  end

  assign mis_mask = mis_mask_q;
  assign err_cnt  = err_cnt_q;
  assign checked  = checked_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign done     = done_q;

endmodule

// File: tb/tb_out_check_monitor.sv
// Bench for out_check_monitor: default instance plus a CHECK_CYCLE=1 / no-drain instance,
// checked against a per-lane reference model with randomized filler stimulus.
module tb_out_check_monitor;

  logic        clk;
  logic        rst;
  logic [31:0] lane_in, exp_in, lane0, exp0;
  logic [3:0]  mis_mask, mis_mask0;
  logic [3:0]  err_cnt, err_cnt0;
  logic        checked, pass, fail, done;
  logic        checked0, pass0, fail0, done0;

  int n_checks;
  int n_errors;

  out_check_monitor dut (
    .clk      (clk),
    .rst      (rst),
    .lane_in  (lane_in),
    .exp_in   (exp_in),
    .mis_mask (mis_mask),
    .err_cnt  (err_cnt),
    .checked  (checked),
    .pass     (pass),
    .fail     (fail),
    .done     (done)
  );

  out_check_monitor #(
    .CHECK_CYCLE  (1),
    .DRAIN_CYCLES (0)
  ) dut0 (
    .clk      (clk),
    .rst      (rst),
    .lane_in  (lane0),
    .exp_in   (exp0),
    .mis_mask (mis_mask0),
    .err_cnt  (err_cnt0),
    .checked  (checked0),
    .pass     (pass0),
    .fail     (fail0),
    .done     (done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a lane mismatches when its byte differs from the expected byte.
  function automatic logic [3:0] model_mask(input logic [31:0] l, input logic [31:0] e);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (l[8*i +: 8] != e[8*i +: 8]);
    return m;
  endfunction

  function automatic int model_count(input logic [3:0] m);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (m[i]) n++;
    return n;
  endfunction

  // Expected word equal to l except in the lanes flagged by bad.
  function automatic logic [31:0] mk_exp(input logic [31:0] l, input logic [3:0] bad);
    logic [31:0] e;
    e = l;
    for (int i = 0; i < 4; i++)
      if (bad[i]) e[8*i +: 8] = l[8*i +: 8] ^ 8'($urandom_range(1, 255));
    return e;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, ".zero"}, {22'd0, mis_mask, err_cnt, checked, pass, fail, done}, 32'd0);
    chk({tag, ".zero0"}, {22'd0, mis_mask0, err_cnt0, checked0, pass0, fail0, done0}, 32'd0);
  endtask

  // One reset-to-done run. Edge e (1-based after reset release) sees inputs set just before it.
  task automatic scenario(input string name, input logic [31:0] cmp_l, input logic [31:0] cmp_e,
                          input logic [31:0] after_l, input bit skip_reset, input int abort_at);
    logic [3:0]  em, em0;
    int          ec, ec0;
    logic [31:0] c0l, c0e;
    if (!skip_reset) begin
      rst     = 1'b1;
      lane_in = $urandom;
      exp_in  = $urandom;
      lane0   = $urandom;
      exp0    = $urandom;
      tick();
      check_zero({name, ".rst"});
      rst = 1'b0;
    end
    em  = model_mask(cmp_l, cmp_e);
    ec  = model_count(em);
    c0l = $urandom;
    c0e = mk_exp(c0l, 4'($urandom));
    em0 = model_mask(c0l, c0e);
    ec0 = model_count(em0);
    for (int e = 1; e <= 106; e++) begin
      lane_in = (e == 4) ? cmp_l : ((e < 4) ? $urandom : after_l);
      exp_in  = (e == 4) ? cmp_e : $urandom;
      lane0   = (e == 2) ? c0l : $urandom;
      exp0    = (e == 2) ? c0e : $urandom;
      if (e == abort_at) begin
        rst = 1'b1;
        tick();
        check_zero({name, ".abort"});
        rst = 1'b0;
        return;
      end
      tick();
      if (e == 1) chk({name, ".d0.pre"}, {31'd0, checked0}, 32'd0);
      if (e == 2) begin
        chk({name, ".d0.mask"}, {28'd0, mis_mask0}, {28'd0, em0});
        chk({name, ".d0.cnt"}, {28'd0, err_cnt0}, 32'(ec0));
        chk({name, ".d0.flags"}, {28'd0, checked0, done0, pass0, fail0},
            {28'd0, 1'b1, 1'b1, ec0 == 0, ec0 != 0});
      end
      if (e == 3) chk({name, ".pre"}, {30'd0, checked, done}, 32'd0);
      if (e == 4) begin
        chk({name, ".mask"}, {28'd0, mis_mask}, {28'd0, em});
        chk({name, ".cnt"}, {28'd0, err_cnt}, 32'(ec));
        chk({name, ".early"}, {28'd0, checked, done, pass, fail}, {28'd0, 4'b1000});
      end
      if (e == 102) chk({name, ".drain"}, {29'd0, done, pass, fail}, 32'd0);
      if (e == 103) chk({name, ".done"}, {29'd0, done, pass, fail},
                        {29'd0, 1'b1, ec == 0, ec != 0});
      if (e == 106) begin
        chk({name, ".hold"}, {20'd0, mis_mask, err_cnt, checked, done, pass, fail},
            {20'd0, em, 4'(ec), 1'b1, 1'b1, ec == 0, ec != 0});
        chk({name, ".d0.hold"}, {20'd0, mis_mask0, err_cnt0, checked0, done0, pass0, fail0},
            {20'd0, em0, 4'(ec0), 1'b1, 1'b1, ec0 == 0, ec0 != 0});
      end
    end
  endtask

  initial begin
    logic [31:0] good, l, ex;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    lane_in  = '0;
    exp_in   = '0;
    lane0    = '0;
    exp0     = '0;
    good     = {8'd16, 8'd16, 8'd17, 8'd17};

    scenario("allpass", good, good, $urandom, 1'b0, 0);
    scenario("c15", {8'd16, 8'd15, 8'd17, 8'd17}, good, good, 1'b0, 0);
    scenario("allbad", 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0);
    scenario("single_shot", good, good, ~good, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      l  = $urandom;
      ex = mk_exp(l, 4'($urandom));
      scenario($sformatf("rand%0d", i), l, ex, $urandom, 1'b0, 0);
    end
    scenario("midreset", good, good, good, 1'b0, 50);
    scenario("restart", {8'd16, 8'd15, 8'd17, 8'd17}, good, $urandom, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
